// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential
// multiply/divide unit.
package muldiv_pkg;

  localparam int ITER = 16;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_seq_addsub.sv
// Combinational add/sub shared by MUL and DIV.
// a, b, op_sub -> sum, cout (sub = a + ~b + 1).
module au_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff = op_sub ? ~b : b;

  assign {cout, sum} = {1'b0, a}
                     + {1'b0, b_eff}
                     + {{WIDTH{1'b0}}, op_sub};

endmodule

// File: rtl/muldiv_seq.sv
// Unsigned shift-add multiply / restoring divide.
// start/op/A/B in; busy, done, res_hi/lo, dz, z out.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             dz,
  output logic             z
);

  localparam int CW = $clog2(WIDTH);

  md_state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic             op_q;
  logic [WIDTH-1:0] hi_q, lo_q, m_q;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [WIDTH-1:0] au_a, au_b, au_sum;
  logic             au_sub, au_cout;
  logic             accept, div0, last;

  assign accept = (state_q == IDLE) && start;
  assign div0   = (op == OP_DIV) && (B == '0);
  assign last   = cnt_q == CW'(WIDTH - 1);

  assign busy = state_q != IDLE;
  assign done = state_q == DONE;

  au_addsub #(.WIDTH(WIDTH)) u_au (
    .a      (au_a),
    .b      (au_b),
    .op_sub (au_sub),
    .sum    (au_sum),
    .cout   (au_cout)
  );

  // One iteration step; hi/lo hold R/Q for DIV.
  always_comb begin
    au_a   = hi_q;
    au_b   = m_q;
    au_sub = 1'b0;
    hi_n   = hi_q;
    lo_n   = lo_q;
    if (op_q == OP_DIV) begin
      au_a   = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      au_sub = 1'b1;
      // A set R msb means t >= 2^WIDTH > D.
      if (hi_q[WIDTH-1] | au_cout) begin
        hi_n = au_sum;
        lo_n = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = au_a;
        lo_n = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else if (lo_q[0]) begin
      hi_n = {au_cout, au_sum[WIDTH-1:1]};
      lo_n = {au_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_n = {1'b0, hi_q[WIDTH-1:1]};
      lo_n = {hi_q[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start)
              state_d = div0 ? DONE : CALC;
      CALC: if (last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      op_q   <= OP_MUL;
      hi_q   <= '0;
      lo_q   <= '0;
      m_q    <= '0;
      res_hi <= '0;
      res_lo <= '0;
      dz     <= 1'b0;
      z      <= 1'b0;
    end else if (accept) begin
      cnt_q  <= '0;
      op_q   <= op;
      hi_q   <= '0;
      lo_q   <= (op == OP_DIV) ? A : B;
      m_q    <= (op == OP_DIV) ? B : A;
      res_hi <= div0 ? A : '0;
      res_lo <= div0 ? '1 : '0;
      dz     <= div0;
      z      <= 1'b0;
    end else if (state_q == CALC) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + CW'(1);
      if (last) begin
        res_hi <= hi_n;
        res_lo <= lo_n;
        z      <= {hi_n, lo_n} == '0;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq.
// Directed vectors, monitor pops on done.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        busy, done, dz, z;
  logic [15:0] res_hi, res_lo;

  typedef struct {
    logic [15:0] hi;
    logic [15:0] lo;
    logic        dz;
    logic        z;
    int          id;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  muldiv_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .res_hi (res_hi),
    .res_lo (res_lo),
    .dz     (dz),
    .z      (z)
  );

  always #5 clk = ~clk;

  // Monitor: every done must match the oldest
  // outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: hi=%h lo=%h, none required",
                 res_hi, res_lo);
      end else begin
        e = sb.pop_front();
        if (res_hi !== e.hi || res_lo !== e.lo ||
            dz !== e.dz || z !== e.z) begin
          errors++;
          $display("FAIL result_%0d: got hi=%h lo=%h dz=%b z=%b, need hi=%h lo=%h dz=%b z=%b",
                   e.id, res_hi, res_lo, dz, z,
                   e.hi, e.lo, e.dz, e.z);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, need %0h",
               name, got, want);
    end
  endtask

  task automatic run_op(input int id,
                        input logic o,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic [15:0] eh,
                        input logic [15:0] el,
                        input logic edz,
                        input logic ez,
                        input bit disturb);
    exp_t e;
    int lat;
    int bc;
    @(negedge clk);
    start = 1'b1;
    op = o;
    A = a;
    B = b;
    e.hi = eh;
    e.lo = el;
    e.dz = edz;
    e.z = ez;
    e.id = id;
    sb.push_back(e);
    bc = 0;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (busy) bc++;
      start = disturb && (lat == 5);
      if (start) begin
        op = OP_DIV;
        A = 16'd100;
        B = 16'd7;
      end
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      errors++;
      $display("FAIL timeout_%0d: no done in %0d cycles, need done",
               id, lat);
      start = 1'b0;
      return;
    end
    bc++;
    if (disturb) begin
      start = 1'b1;
      op = OP_MUL;
      A = 16'hFFFF;
      B = 16'hFFFF;
    end
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("latency_%0d", id), lat,
        edz ? 32'd1 : 32'd17);
    chk($sformatf("busy_cycles_%0d", id), bc,
        edz ? 32'd1 : 32'd17);
    chk($sformatf("idle_after_%0d", id),
        {30'd0, busy, done}, 32'd0);
    chk($sformatf("held_%0d", id),
        {res_hi, res_lo}, {eh, el});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {12'd0, busy, done, dz, z, res_hi},
        32'd0);
    chk("reset_lo", {16'd0, res_lo}, 32'd0);
    rst_n = 1'b1;

    run_op(1, OP_MUL, 16'd3, 16'd5,
           16'h0000, 16'd15, 1'b0, 1'b0, 1'b0);
    run_op(2, OP_MUL, 16'hFFFF, 16'hFFFF,
           16'hFFFE, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(3, OP_MUL, 16'd0, 16'd1234,
           16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op(4, OP_MUL, 16'h1234, 16'h0100,
           16'h0012, 16'h3400, 1'b0, 1'b0, 1'b0);
    run_op(5, OP_DIV, 16'd100, 16'd7,
           16'd2, 16'd14, 1'b0, 1'b0, 1'b0);
    run_op(6, OP_DIV, 16'hFFFF, 16'd1,
           16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    run_op(7, OP_DIV, 16'h8000, 16'hFFFF,
           16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_op(8, OP_DIV, 16'd9, 16'd0,
           16'd9, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op(9, OP_DIV, 16'd0, 16'd5,
           16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    run_op(10, OP_DIV, 16'd1000, 16'd1000,
           16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);

    // Restarts during CALC and DONE are ignored.
    run_op(11, OP_MUL, 16'd3, 16'd5,
           16'h0000, 16'd15, 1'b0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    chk("no_queued_op",
        {30'd0, busy, done}, 32'd0);
    chk("result_kept", {res_hi, res_lo}, 32'd15);

    // Abort mid-CALC with reset.
    @(negedge clk);
    start = 1'b1;
    op = OP_MUL;
    A = 16'd7;
    B = 16'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("busy_before_abort", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_outputs",
        {12'd0, busy, done, dz, z, res_hi},
        32'd0);
    chk("abort_lo", {16'd0, res_lo}, 32'd0);
    repeat (20) @(negedge clk);
    chk("abort_idle", {30'd0, busy, done}, 32'd0);

    run_op(12, OP_MUL, 16'd3, 16'd5,
           16'h0000, 16'd15, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
